// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: two-requester external memory arbiter with response timeout; define ARB_ROUND_ROBIN_EN for round-robin ties instead of fixed priority.
module ext_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [1:0]       we_i,
    input  logic [1:0][3:0]  be_i,
    input  logic [1:0][31:0] addr_i,
    input  logic [1:0][31:0] wdata_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_ready_i
);
    localparam logic IDLE = 1'b0;
    localparam logic RESP = 1'b1;
    logic       state_q, state_d, owner_q, owner_d, last_gnt_q, last_gnt_d, we_q, we_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       sel, grant, resp, tmo;
`ifdef ARB_ROUND_ROBIN_EN
    assign sel = &req_i ? ~last_gnt_q : req_i[1];
`else
    assign sel = req_i[1];
`endif
    always_comb begin
        grant       = !rst_i && (state_q == IDLE || mem_ready_i) && |req_i;
        resp        = !rst_i && state_q == RESP && mem_ready_i;
        tmo         = !rst_i && state_q == RESP && !mem_ready_i && wait_cnt_q == 8'(TIMEOUT_CYCLES - 1);
        gnt_o       = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
        mem_req_o   = grant;
        mem_we_o    = grant && we_i[sel];
        mem_be_o    = grant ? be_i[sel] : 4'h0;
        mem_addr_o  = grant ? addr_i[sel] : 32'h0;
        mem_wdata_o = grant ? wdata_i[sel] : 32'h0;
        rvalid_o    = (resp || tmo) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        rdata_o     = (resp && !we_q) ? mem_rdata_i : 32'h0;
        err_o       = tmo;
        state_d     = grant ? RESP : (resp || tmo) ? IDLE : state_q;
        owner_d     = grant ? sel : owner_q;
        last_gnt_d  = grant ? sel : last_gnt_q;
        we_d        = grant ? we_i[sel] : we_q;
        wait_cnt_d  = (grant || resp || tmo) ? 8'd0 : (state_q == RESP) ? wait_cnt_q + 8'd1 : wait_cnt_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: cycle-by-cycle vector table plus timeout and reset sequences for ext_mem_arbiter.
module tb_ext_mem_arbiter;
    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       req_i, we_i, gnt_o, rvalid_o;
    logic [1:0][3:0]  be_i;
    logic [1:0][31:0] addr_i, wdata_i;
    logic [31:0]      rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic             err_o, mem_req_o, mem_we_o, mem_ready_i;
    logic [3:0]       mem_be_o;
    int               n_chk = 0;
    int               n_fail = 0;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {
        logic rst; logic [1:0] req; logic [1:0] we; logic [31:0] a0; logic [31:0] a1; logic [31:0] wd1; logic [3:0] be1;
        logic rdy; logic [31:0] rd;
        logic [1:0] gnt; logic [1:0] rv; logic [31:0] rdat; logic err; logic [31:0] maddr; logic mwe; logic [3:0] mbe; logic [31:0] mwd;
    } vec_t;
    vec_t v[18];
    ext_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic run(input vec_t x, input string t);
        rst_i = x.rst; req_i = x.req; we_i = x.we; addr_i[0] = x.a0; addr_i[1] = x.a1;
        wdata_i[0] = 32'h0; wdata_i[1] = x.wd1; be_i[0] = 4'hF; be_i[1] = x.be1;
        mem_ready_i = x.rdy; mem_rdata_i = x.rd;
        #3;
        chk({t, ".gnt"}, 32'(gnt_o), 32'(x.gnt));
        chk({t, ".rvalid"}, 32'(rvalid_o), 32'(x.rv));
        chk({t, ".rdata"}, rdata_o, x.rdat);
        chk({t, ".err"}, 32'(err_o), 32'(x.err));
        chk({t, ".mem_req"}, 32'(mem_req_o), 32'(|x.gnt));
        chk({t, ".mem_addr"}, mem_addr_o, x.maddr);
        chk({t, ".mem_we"}, 32'(mem_we_o), 32'(x.mwe));
        chk({t, ".mem_be"}, 32'(mem_be_o), 32'(x.mbe));
        chk({t, ".mem_wdata"}, mem_wdata_o, x.mwd);
        @(posedge clk_i);
        #1;
    endtask
    initial begin
        logic [1:0] g, gp, tie;
        v[0]  = '{1'b1, 2'b01, '0, '0, '0, '0, 4'hF, 1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0};
        v[1]  = '{1'b1, 2'b00, '0, '0, '0, '0, 4'hF, 1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0};
        v[2]  = '{1'b0, 2'b01, '0, 32'h10, '0, '0, 4'hF, 1'b0, '0, 2'b01, '0, '0, 1'b0, 32'h10, 1'b0, 4'hF, '0};
        v[3]  = '{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'hDEADBEEF, '0, 2'b01, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0};
        v[4]  = '{1'b0, 2'b01, '0, 32'h14, '0, '0, 4'hF, 1'b0, '0, 2'b01, '0, '0, 1'b0, 32'h14, 1'b0, 4'hF, '0};
        v[5]  = '{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'h11111111, '0, 2'b01, 32'h11111111, 1'b0, '0, 1'b0, '0, '0};
        v[6]  = '{1'b0, 2'b10, 2'b10, '0, 32'h20, 32'h12345678, 4'b0011, 1'b0, '0, 2'b10, '0, '0, 1'b0, 32'h20, 1'b1, 4'b0011, 32'h12345678};
        v[7]  = '{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'hCAFEF00D, '0, 2'b10, '0, 1'b0, '0, 1'b0, '0, '0};
        v[8]  = '{1'b0, 2'b10, '0, '0, 32'h0, '0, 4'hF, 1'b0, '0, 2'b10, '0, '0, 1'b0, 32'h0, 1'b0, 4'hF, '0};
        v[9]  = '{1'b0, 2'b10, '0, '0, 32'h4, '0, 4'hF, 1'b1, 32'hA0, 2'b10, 2'b10, 32'hA0, 1'b0, 32'h4, 1'b0, 4'hF, '0};
        v[10] = '{1'b0, 2'b10, '0, '0, 32'h8, '0, 4'hF, 1'b1, 32'hA4, 2'b10, 2'b10, 32'hA4, 1'b0, 32'h8, 1'b0, 4'hF, '0};
        v[11] = '{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'hA8, '0, 2'b10, 32'hA8, 1'b0, '0, 1'b0, '0, '0};
        v[12] = '{1'b1, 2'b00, '0, '0, '0, '0, 4'hF, 1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0};
        gp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            g = RR ? ((i % 2) ? 2'b10 : 2'b01) : 2'b10;
            v[13 + i] = '{1'b0, 2'b11, '0, 32'h100, 32'h200, '0, 4'hF, 1'b1, 32'h55, g, gp, (i == 0) ? 32'h0 : 32'h55, 1'b0,
                          g[1] ? 32'h200 : 32'h100, 1'b0, 4'hF, '0};
            gp = g;
        end
        v[17] = '{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'h66, '0, gp, 32'h66, 1'b0, '0, 1'b0, '0, '0};
        rst_i = 1'b1; req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 18; i++) run(v[i], $sformatf("v%0d", i));
        run('{1'b0, 2'b01, '0, 32'h30, 32'h40, '0, 4'hF, 1'b0, '0, 2'b01, '0, '0, 1'b0, 32'h30, 1'b0, 4'hF, '0}, "to_gnt");
        for (int i = 0; i < 3; i++)
            run('{1'b0, 2'b11, '0, 32'h30, 32'h40, '0, 4'hF, 1'b0, 32'hBAD, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0}, $sformatf("to_wait%0d", i));
        run('{1'b0, 2'b11, '0, 32'h30, 32'h40, '0, 4'hF, 1'b0, 32'hBAD, '0, 2'b01, '0, 1'b1, '0, 1'b0, '0, '0}, "to_abort");
        run('{1'b0, 2'b11, '0, 32'h30, 32'h40, '0, 4'hF, 1'b0, '0, 2'b10, '0, '0, 1'b0, 32'h40, 1'b0, 4'hF, '0}, "to_idle");
        run('{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'h99, '0, 2'b10, 32'h99, 1'b0, '0, 1'b0, '0, '0}, "to_after");
        run('{1'b0, 2'b01, '0, 32'h50, 32'h60, '0, 4'hF, 1'b0, '0, 2'b01, '0, '0, 1'b0, 32'h50, 1'b0, 4'hF, '0}, "rs_gnt");
        run('{1'b1, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'h77, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0}, "rs_rst");
        tie = RR ? 2'b01 : 2'b10;
        run('{1'b0, 2'b11, '0, 32'h50, 32'h60, '0, 4'hF, 1'b0, 32'h77, tie, '0, '0, 1'b0, tie[1] ? 32'h60 : 32'h50, 1'b0, 4'hF, '0}, "rs_tie");
        run('{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'h88, '0, tie, 32'h88, 1'b0, '0, 1'b0, '0, '0}, "rs_resp");
        run('{1'b0, 2'b00, '0, '0, '0, '0, 4'hF, 1'b1, 32'h89, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0}, "rs_idle");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ext_mem_arbiter.md
EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of RESP cycles with mem_ready_i low before the transaction is aborted; legal range 2..255.
REQ-002 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port req_i, input, [1:0], per-requester request; port 0 is instruction fetch, port 1 is data LSU.
REQ-005 SHALL have port we_i, input, [1:0], per-requester write enable.
REQ-006 SHALL have port be_i, input, [1:0][3:0], per-requester byte enables.
REQ-007 SHALL have port addr_i, input, [1:0][31:0], per-requester byte address.
REQ-008 SHALL have port wdata_i, input, [1:0][31:0], per-requester write data.
REQ-009 SHALL have port gnt_o, input-accepted strobe, output, [1:0], one-hot or zero, combinational.
REQ-010 SHALL have port rvalid_o, output, [1:0], per-requester response strobe, at most one bit set.
REQ-011 SHALL have port rdata_o, output, [31:0], response data, shared by both requesters and qualified by rvalid_o.
REQ-012 SHALL have port err_o, output, 1, timeout strobe, coincident with the aborted rvalid_o.
REQ-013 SHALL have ports mem_req_o (1), mem_we_o (1), mem_be_o [3:0], mem_addr_o [31:0] and mem_wdata_o [31:0], all outputs, which drive the memory.
REQ-014 SHALL have ports mem_rdata_i [31:0] and mem_ready_i (1), both inputs, from the memory; memory read data is registered, one-cycle latency.

Function
REQ-015 SHALL implement states IDLE and RESP, plus registers owner (1 bit), last_gnt (1 bit) and wait_cnt (8 bits).
REQ-016 SHALL define a grant opportunity as: state IDLE, or state RESP with mem_ready_i=1.
REQ-017 SHALL, at a grant opportunity with any req_i set, assert exactly one gnt_o[k] and mem_req_o=1, and drive the mem_* fields combinationally from port k in the same cycle.
REQ-018 SHALL drive mem_req_o=0 and gnt_o=0 when there is no grant opportunity; mem_* fields then SHALL hold 0.
REQ-019 SHALL, on a grant, set state RESP, owner=k, last_gnt=k and wait_cnt=0 at the next edge.
REQ-020 SHALL, in RESP with mem_ready_i=1, assert rvalid_o[owner]=1 with rdata_o=mem_rdata_i; rdata_o SHALL be 0 for writes, and a write response is an acknowledge only.
REQ-021 SHALL go from RESP to IDLE after the response if no grant occurs in that cycle; a simultaneous grant keeps RESP, giving a throughput of one transaction per cycle.
REQ-022 SHALL, in RESP with mem_ready_i=0, increment wait_cnt.
REQ-023 SHALL, in RESP with mem_ready_i=0 and wait_cnt=TIMEOUT_CYCLES-1, assert rvalid_o[owner]=1, err_o=1 and rdata_o=0 for one cycle, then go to IDLE; no grant occurs in that cycle.
REQ-024 SHALL keep rvalid_o, rdata_o and err_o at 0 in all other cycles.
REQ-025 SHALL accept a single request immediately regardless of last_gnt.
REQ-026 SHALL sample requester inputs only in the grant cycle; a requester holds its fields until gnt_o is seen.

Reset
REQ-027 SHALL, while rst_i=1 at an edge, set state=IDLE, owner=0, last_gnt=1 and wait_cnt=0.
REQ-028 SHALL force gnt_o, rvalid_o, err_o and mem_req_o to 0 during any cycle with rst_i=1.
REQ-029 SHALL, on reset in RESP, drop the outstanding response and never report it after reset.

Configuration
REQ-030 SHALL use macro ARB_ROUND_ROBIN_EN.
REQ-031 SHALL, when ARB_ROUND_ROBIN_EN is defined and both ports request, grant the port != last_gnt.
REQ-032 SHALL, when ARB_ROUND_ROBIN_EN is undefined, use fixed priority: port 1 (data) always wins ties; last_gnt is still updated but does not affect arbitration.

Verification
REQ-033 Bench SHALL cover single read: port 0 req, addr 0x10, mem returns 0xDEADBEEF next cycle -> gnt_o=01 at cycle N, rvalid_o=01 with rdata_o=0xDEADBEEF at N+1, IDLE at N+2.
REQ-034 Bench SHALL cover simultaneous requests from reset, with round robin: both req held 4 cycles -> grants 0,1,0,1 back-to-back; without the macro: grants 1,1,1,1 and port 0 starved.
REQ-035 Bench SHALL cover a write: port 1 we=1, be=0011, addr 0x20, data 0x12345678 -> mem_be_o=0011, mem_wdata_o=0x12345678, rvalid_o=10 next cycle with rdata_o=0.
REQ-036 Bench SHALL cover timeout: mem_ready_i held 0 after a port 0 grant, TIMEOUT_CYCLES=4 -> rvalid_o=01 and err_o=1 in the 4th RESP cycle, then IDLE, and no gnt_o during the wait.
REQ-037 Bench SHALL cover reset mid-operation: rst_i=1 in the RESP cycle -> no rvalid_o; next tie grants port 0 under round robin.
REQ-038 Bench SHALL cover pipelined back-to-back: port 1 issues reads 0x0, 0x4, 0x8 on consecutive cycles with mem_ready_i=1 -> three consecutive rvalid_o=10 with matching data order.
